program_counter2: RTL and testbench

PROGRAM_COUNTER2 -- requirements
Module: program_counter2

---
 rtl/program_counter2.sv | 47 ++++
 tb/tb_program_counter2.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/program_counter2.sv
// 64-bit program counter with a four-way next-PC mux.
// The mux selects hold, PC+4, an absolute target, or a relative word-offset branch.
module program_counter2 (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  PS,
    input  logic [63:0] in,
    output logic [63:0] PC,
    output logic [63:0] PC4
);

    logic [63:0] reg_out_r;
    logic [63:0] add_out_s;
    logic [63:0] offset_s;
    logic [63:0] mux_out_s;

    // Incrementer and branch-target offset; the offset is in words and the shift drops bits above 63.
    always_comb begin
        add_out_s = reg_out_r + 64'd4;
        offset_s  = {in[61:0], 2'b00};
    end

    // Next-PC selection.
    always_comb begin
        mux_out_s = reg_out_r;
        case (PS)
            2'b00:   mux_out_s = reg_out_r;
            2'b01:   mux_out_s = add_out_s;
            2'b10:   mux_out_s = in;
            2'b11:   mux_out_s = reg_out_r + offset_s;
            default: mux_out_s = reg_out_r;
        endcase
    end

    // PC register; reset overrides every mux selection.
    always_ff @(posedge clock) begin
        if (reset) begin
            reg_out_r <= 64'h0;
        end else begin
            reg_out_r <= mux_out_s;
        end
    end

    assign PC  = reg_out_r;
    assign PC4 = add_out_s;

endmodule

// File: tb/tb_program_counter2.sv
// Self-checking bench for program_counter2: directed scenarios plus random
// stimulus compared against an arithmetic reference model.
module tb_program_counter2;

    logic        clock;
    logic        reset;
    logic [1:0]  PS;
    logic [63:0] in;
    logic [63:0] PC;
    logic [63:0] PC4;

    logic [63:0] pc_m;
    int          errors;
    int          checks;

    program_counter2 dut (
        .clock(clock),
        .reset(reset),
        .PS(PS),
        .in(in),
        .PC(PC),
        .PC4(PC4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Apply inputs on the falling edge, take one rising edge, advance the model.
    task automatic drive(input logic r, input logic [1:0] ps_v, input logic [63:0] in_v);
        @(negedge clock);
        reset = r;
        PS    = ps_v;
        in    = in_v;
        @(posedge clock);
        #1;
        if (r) begin
            pc_m = 64'd0;
        end else begin
            case (ps_v)
                2'd0:    pc_m = pc_m;
                2'd1:    pc_m = pc_m + 64'd4;
                2'd2:    pc_m = in_v;
                default: pc_m = pc_m + in_v * 64'd4;
            endcase
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'($urandom_range(0, 3)), {$urandom, $urandom});
            checks++;
            if (PC !== 64'h0) begin
                errors++;
                $display("FAIL reset_pc: got %h expected %h", PC, 64'h0);
            end
            checks++;
            if (PC4 !== 64'h4) begin
                errors++;
                $display("FAIL reset_pc4: got %h expected %h", PC4, 64'h4);
            end
        end
    endtask

    task automatic test_increment();
        logic [63:0] exp_v;
        exp_v = 64'd0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b01, 64'd0);
            exp_v = exp_v + 64'd4;
            checks++;
            if (PC !== exp_v) begin
                errors++;
                $display("FAIL increment: got %h expected %h", PC, exp_v);
            end
        end
    endtask

    task automatic test_hold();
        drive(1'b0, 2'b10, 64'h10);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b00, {$urandom, $urandom});
            checks++;
            if (PC !== 64'h10 || PC4 !== 64'h14) begin
                errors++;
                $display("FAIL hold: got PC=%h PC4=%h expected 10/14", PC, PC4);
            end
        end
    endtask

    task automatic test_jump();
        drive(1'b0, 2'b10, 64'h0000_0000_1234_5678);
        checks++;
        if (PC !== 64'h1234_5678 || PC4 !== 64'h1234_567C) begin
            errors++;
            $display("FAIL jump: got PC=%h PC4=%h expected 12345678/1234567c", PC, PC4);
        end
        drive(1'b0, 2'b10, 64'hDEAD_BEEF_0000_0003);
        checks++;
        if (PC !== 64'hDEAD_BEEF_0000_0003) begin
            errors++;
            $display("FAIL jump_unaligned: got %h expected %h", PC, 64'hDEAD_BEEF_0000_0003);
        end
    endtask

    task automatic test_branch();
        drive(1'b0, 2'b10, 64'h100);
        drive(1'b0, 2'b11, 64'd3);
        checks++;
        if (PC !== 64'h10C) begin
            errors++;
            $display("FAIL branch_fwd: got %h expected %h", PC, 64'h10C);
        end
        drive(1'b0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFE);
        checks++;
        if (PC !== 64'h104) begin
            errors++;
            $display("FAIL branch_back: got %h expected %h", PC, 64'h104);
        end
        // Top two offset bits fall off the shift: effective offset is +4.
        drive(1'b0, 2'b11, 64'hC000_0000_0000_0001);
        checks++;
        if (PC !== 64'h108) begin
            errors++;
            $display("FAIL branch_shift: got %h expected %h", PC, 64'h108);
        end
    endtask

    task automatic test_wrap();
        drive(1'b0, 2'b10, 64'hFFFF_FFFF_FFFF_FFFC);
        checks++;
        if (PC4 !== 64'h0) begin
            errors++;
            $display("FAIL wrap_pc4: got %h expected %h", PC4, 64'h0);
        end
        drive(1'b0, 2'b01, 64'd0);
        checks++;
        if (PC !== 64'h0) begin
            errors++;
            $display("FAIL wrap_pc: got %h expected %h", PC, 64'h0);
        end
    endtask

    task automatic test_cycle_mid_reset();
        logic r;
        for (int i = 0; i < 12; i++) begin
            r = (i == 7);
            drive(r, 2'(i / 3), {$urandom, $urandom});
            checks++;
            if (PC !== pc_m) begin
                errors++;
                $display("FAIL cycle_edge%0d: got %h expected %h", i, PC, pc_m);
            end
            if (r) begin
                checks++;
                if (PC !== 64'h0) begin
                    errors++;
                    $display("FAIL cycle_reset: got %h expected %h", PC, 64'h0);
                end
            end
            // Disturb the inputs between edges; PC must not move.
            #1;
            PS    = 2'($urandom_range(0, 3));
            in    = {$urandom, $urandom};
            reset = 1'b1;
            #1;
            checks++;
            if (PC !== pc_m) begin
                errors++;
                $display("FAIL no_glitch%0d: got %h expected %h", i, PC, pc_m);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] in_v;
        for (int i = 0; i < 300; i++) begin
            in_v = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) begin
                in_v = {{48{in_v[15]}}, in_v[15:0]};
            end
            drive(($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)), in_v);
            checks++;
            if (PC !== pc_m || PC4 !== pc_m + 64'd4 || $isunknown({PC, PC4})) begin
                errors++;
                $display("FAIL random%0d: got PC=%h PC4=%h expected PC=%h", i, PC, PC4, pc_m);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        pc_m   = 64'd0;
        reset  = 1'b1;
        PS     = 2'b01;
        in     = 64'd0;
        test_reset();
        test_increment();
        test_hold();
        test_jump();
        test_branch();
        test_wrap();
        test_cycle_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
